// File: rtl/icb_pkg.sv
// Shared types and constants for the ICB DMA master.
//   dma_state_e : controller state encoding
//   WordStride  : byte distance between consecutive 32-bit words
package icb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRdCmd,
    StRdRsp,
    StWrCmd,
    StWrRsp,
    StDone
  } dma_state_e;

  localparam int unsigned WordStride = 4;

endpackage

// File: rtl/icb_dma_master.sv
// Single-channel word-copy DMA engine with an ICB master port.
// Copies len 32-bit words from src_base to dst_base, one read then one write per
// word, with at most one ICB transaction in flight.
//   clk, rst_n                      : clock, asynchronous active-low reset
//   start, src_base, dst_base, len  : job request (accepted only when idle)
//   busy, done, err                 : job active, completion pulse, sticky error
//   icb_cmd_*                       : ICB command channel (master side)
//   icb_rsp_*                       : ICB response channel (master side)
module icb_dma_master
  import icb_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      src_base,
  input  logic [31:0]      dst_base,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             icb_cmd_valid,
  input  logic             icb_cmd_ready,
  output logic             icb_cmd_read,
  output logic [31:0]      icb_cmd_addr,
  output logic [31:0]      icb_cmd_wdata,
  output logic [3:0]       icb_cmd_wmask,
  input  logic             icb_rsp_valid,
  output logic             icb_rsp_ready,
  input  logic [31:0]      icb_rsp_rdata,
  input  logic             icb_rsp_err
);

  dma_state_e       state_q, state_d;
  logic [31:0]      src_q, src_d;
  logic [31:0]      dst_q, dst_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] i_q, i_d;
  logic [31:0]      buf_q, buf_d;
  logic             err_q, err_d;

  logic [31:0] word_off;
  logic        last_word;

  // 32-bit wrap-around of base + offset is intentional.
  assign word_off  = 32'(i_q) * WordStride;
  assign last_word = (i_q == len_q - LEN_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      i_q     <= '0;
      buf_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      len_q   <= len_d;
      i_q     <= i_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    i_d     = i_q;
    buf_d   = buf_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d   = src_base;
          dst_d   = dst_base;
          len_d   = len;
          i_d     = '0;
          err_d   = 1'b0;
          state_d = StRdCmd;
        end
      end
      StRdCmd: begin
        // Empty job: finish without ever raising a command.
        if (len_q == '0) begin
          state_d = StDone;
        end else if (icb_cmd_ready) begin
          state_d = StRdRsp;
        end
      end
      StRdRsp: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else begin
            buf_d   = icb_rsp_rdata;
            state_d = StWrCmd;
          end
        end
      end
      StWrCmd: begin
        if (icb_cmd_ready) begin
          state_d = StWrRsp;
        end
      end
      StWrRsp: begin
        if (icb_rsp_valid) begin
          if (icb_rsp_err) begin
            err_d   = 1'b1;
            state_d = StDone;
          end else if (last_word) begin
            state_d = StDone;
          end else begin
            i_d     = i_q + LEN_W'(1);
            state_d = StRdCmd;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Outputs depend on registered state only, so they stay stable during a stall.
  always_comb begin
    icb_cmd_valid = 1'b0;
    icb_cmd_read  = 1'b0;
    icb_cmd_addr  = '0;
    icb_cmd_wdata = '0;
    icb_cmd_wmask = '0;
    icb_rsp_ready = 1'b0;
    unique case (state_q)
      StRdCmd: begin
        if (len_q != '0) begin
          icb_cmd_valid = 1'b1;
          icb_cmd_read  = 1'b1;
          icb_cmd_addr  = src_q + word_off;
        end
      end
      StWrCmd: begin
        icb_cmd_valid = 1'b1;
        icb_cmd_addr  = dst_q + word_off;
        icb_cmd_wdata = buf_q;
        icb_cmd_wmask = 4'hF;
      end
      StRdRsp, StWrRsp: begin
        icb_rsp_ready = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign busy = (state_q != StIdle);
  assign done = (state_q == StDone);
  assign err  = err_q;

endmodule

// File: doc/icb_dma_master.md
ICB_DMA_MASTER -- requirements
Module: icb_dma_master

Interface
REQ-001 SHALL have parameter LEN_W, default 16, giving the width of the word-count port.
REQ-002 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  one-cycle job request.
REQ-005 SHALL have port src_base  input  32  byte address of the first source word.
REQ-006 SHALL have port dst_base  input  32  byte address of the first destination word.
REQ-007 SHALL have port len  input  LEN_W  number of 32-bit words to copy.
REQ-008 SHALL have ports busy, done and err  output  1 each  job active, one-cycle completion pulse, and sticky error flag.
REQ-009 SHALL have ICB master command ports: icb_cmd_valid out 1, icb_cmd_ready in 1, icb_cmd_read out 1, icb_cmd_addr out 32, icb_cmd_wdata out 32, icb_cmd_wmask out 4.
REQ-010 SHALL have ICB master response ports: icb_rsp_valid in 1, icb_rsp_ready out 1, icb_rsp_rdata in 32, icb_rsp_err in 1.

Function
REQ-011 SHALL implement the states IDLE, RD_CMD, RD_RSP, WR_CMD, WR_RSP and DONE, with at most one ICB transaction outstanding.
REQ-012 SHALL accept start only in IDLE, latching src_base, dst_base and len, clearing err and the word index i, and moving to RD_CMD on the next cycle; start is ignored in any other state.
REQ-013 SHALL, when the accepted len is 0, go directly to DONE with no ICB traffic.
REQ-014 SHALL, in RD_CMD, drive icb_cmd_valid=1, icb_cmd_read=1 and icb_cmd_addr=src+4*i, and move to RD_RSP on the valid&ready handshake.
REQ-015 SHALL hold icb_cmd_valid, icb_cmd_addr, icb_cmd_read, icb_cmd_wdata and icb_cmd_wmask stable while valid is high and ready is low.
REQ-016 SHALL, in RD_RSP, drive icb_rsp_ready=1 and, on icb_rsp_valid, capture icb_rsp_rdata into a one-word buffer and move to WR_CMD, or to DONE with err set if icb_rsp_err=1.
REQ-017 SHALL, in WR_CMD, drive icb_cmd_valid=1, icb_cmd_read=0, icb_cmd_addr=dst+4*i, icb_cmd_wdata=buffer and icb_cmd_wmask=4'hF, and move to WR_RSP on the handshake.
REQ-018 SHALL, in WR_RSP, drive icb_rsp_ready=1 and, on icb_rsp_valid, take one of three transitions:
- icb_rsp_err=1: set err and go to DONE;
- else i==len-1: go to DONE;
- else: increment i and go to RD_CMD.
REQ-019 SHALL assert icb_rsp_ready only in RD_RSP and WR_RSP, and icb_cmd_valid only in RD_CMD and WR_CMD.
REQ-020 SHALL compute addresses modulo 2^32, so a wrap past 0xFFFF_FFFC continues at 0x0000_0000.
REQ-021 SHALL assert done for exactly one cycle in DONE, then return to IDLE; busy is 1 in every state except IDLE.
REQ-022 SHALL keep err set after a job until the next accepted start, and SHALL terminate the job at the first error response.
REQ-023 SHALL take exactly 4 cycles per word with a zero-wait slave (ready=1 and response valid in the cycle after the handshake), so a start in cycle 0 gives done in cycle 1+4*len.
REQ-024 SHALL drive icb_cmd_wdata=0 and icb_cmd_wmask=0 when not in WR_CMD.

Reset
REQ-025 SHALL, on rst_n low at any time including mid-transaction, immediately enter IDLE and drive busy=0, done=0, err=0, icb_cmd_valid=0, icb_cmd_read=0, icb_cmd_addr=0, icb_cmd_wdata=0, icb_cmd_wmask=0 and icb_rsp_ready=0, and clear the buffer and i.
REQ-026 SHALL ignore any response that arrives after reset is released for a transaction issued before reset.

Structure
REQ-027 SHALL place the state enum type and the word-stride constant (4) in the shared package icb_pkg.
REQ-028 SHALL be a single module with no sub-modules; the state register, index counter and data buffer are local.

Verification
REQ-029 Zero-wait slave, src=0x1000, dst=0x2000, len=4 -> reads 0x1000..0x100C, writes 0x2000..0x200C with matching data, done at cycle 17, err=0.
REQ-030 Slave holds icb_cmd_ready=0 for 3 cycles on each command -> all command fields stable throughout, data correct, done at cycle 1+4*len+6*len.
REQ-031 len=0 with start -> done pulses at cycle 2, no icb_cmd_valid ever asserted.
REQ-032 Error response on the 2nd read, len=4 -> exactly 1 write issued, done with err=1, err cleared by the next start.
REQ-033 src=0xFFFF_FFF8, len=3 -> read addresses 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-034 rst_n pulsed low while in WR_RSP, then start is pulsed again -> all outputs 0 during reset, the new job completes correctly, and the stale response is ignored.
